// File: rtl/eth_pkg.sv
// Shared constants and types for the port-1 store-and-forward packet FIFO.
// The AXIS widths here are the defaults; eth_pkt_fifo may be parameterised away from them.
package eth_pkg;

   localparam int AXIS_DATA_WIDTH  = 64;
   localparam int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8;
   // One buffer entry is {tlast, tkeep, tdata}.
   localparam int AXIS_ENTRY_WIDTH = 1 + AXIS_KEEP_WIDTH + AXIS_DATA_WIDTH;

   typedef enum logic [0:0] {
      W_ACCEPT = 1'b0,
      W_DROP   = 1'b1
   } wr_state_t;

endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a registered output.
// The read register holds its value while rd_en is low, so the read pipeline can stall.
module eth_pkt_fifo_ram
   import eth_pkg::*;
#(
   parameter int ADDR_WIDTH  = 9,
   parameter int ENTRY_WIDTH = AXIS_ENTRY_WIDTH
) (
   input  logic                   clk156,
   input  logic                   wr_en,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [ENTRY_WIDTH-1:0] wr_data,
   input  logic                   rd_en,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [ENTRY_WIDTH-1:0] rd_data
);

   logic [ENTRY_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
   logic [ENTRY_WIDTH-1:0] rd_data_reg;

   always_ff @(posedge clk156) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO between the 10G MAC RX and TX: whole frames only,
// bad (tuser) and overflowing frames are discarded by rewinding wr_ptr to commit_ptr.
module eth_pkt_fifo
   import eth_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 9,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk156,
   input  logic                  eth_rst,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  overflow
);

   localparam int ENTRY_WIDTH = 1 + KEEP_WIDTH + DATA_WIDTH;
   localparam int PTR_WIDTH   = ADDR_WIDTH + 1;
   localparam logic [PTR_WIDTH-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   wr_state_t              state_reg, state_next;
   logic [PTR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_WIDTH-1:0]   commit_ptr_reg, commit_ptr_next;
   logic [PTR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [CNT_WIDTH-1:0]   drop_cnt_reg, drop_cnt_next;
   logic [CNT_WIDTH-1:0]   frame_cnt_reg, frame_cnt_next;
   logic                   overflow_reg, overflow_next;

   logic                   s1_valid_reg, s1_valid_next;
   logic                   m_valid_reg, m_valid_next;
   logic [DATA_WIDTH-1:0]  m_data_reg, m_data_next;
   logic [KEEP_WIDTH-1:0]  m_keep_reg, m_keep_next;
   logic                   m_last_reg, m_last_next;

   logic                   full;
   logic                   ram_wr_en;
   logic [ENTRY_WIDTH-1:0] wr_entry;
   logic [ENTRY_WIDTH-1:0] rd_entry;
   logic                   avail;
   logic                   load_out;
   logic                   rd_en;

   // Space is judged against the registered rd_ptr: a read this cycle frees nothing until next cycle.
   assign full     = (wr_ptr_reg - rd_ptr_reg) == DEPTH;
   assign wr_entry = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

   always_comb begin
      state_next      = state_reg;
      wr_ptr_next     = wr_ptr_reg;
      commit_ptr_next = commit_ptr_reg;
      drop_cnt_next   = drop_cnt_reg;
      overflow_next   = 1'b0;
      ram_wr_en       = 1'b0;
      case (state_reg)
         W_ACCEPT: begin
            if (s_axis_tvalid) begin
               if (!full) begin
                  ram_wr_en   = 1'b1;
                  wr_ptr_next = wr_ptr_reg + 1'b1;
                  if (s_axis_tlast) begin
                     if (s_axis_tuser) begin
                        wr_ptr_next   = commit_ptr_reg;
                        drop_cnt_next = drop_cnt_reg + 1'b1;
                     end else begin
                        commit_ptr_next = wr_ptr_reg + 1'b1;
                     end
                  end
               end else begin
                  // Out of space: discard the partial frame and skip its remaining beats.
                  wr_ptr_next   = commit_ptr_reg;
                  drop_cnt_next = drop_cnt_reg + 1'b1;
                  overflow_next = 1'b1;
                  if (!s_axis_tlast) begin
                     state_next = W_DROP;
                  end
               end
            end
         end
         W_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_next = W_ACCEPT;
            end
         end
         default: state_next = W_ACCEPT;
      endcase
   end

   // Two-stage read: RAM output register (s1) feeding the AXIS output register.
   assign avail    = rd_ptr_reg != commit_ptr_reg;
   assign load_out = s1_valid_reg && (!m_valid_reg || m_axis_tready);
   assign rd_en    = avail && (!s1_valid_reg || load_out);

   always_comb begin
      rd_ptr_next    = rd_ptr_reg;
      s1_valid_next  = s1_valid_reg;
      m_valid_next   = m_valid_reg;
      m_data_next    = m_data_reg;
      m_keep_next    = m_keep_reg;
      m_last_next    = m_last_reg;
      frame_cnt_next = frame_cnt_reg;
      if (m_valid_reg && m_axis_tready) begin
         m_valid_next = 1'b0;
         if (m_last_reg) begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
         end
      end
      if (load_out) begin
         m_valid_next                           = 1'b1;
         {m_last_next, m_keep_next, m_data_next} = rd_entry;
         s1_valid_next                          = 1'b0;
      end
      if (rd_en) begin
         s1_valid_next = 1'b1;
         rd_ptr_next   = rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk156) begin
      if (eth_rst) begin
         state_reg      <= W_ACCEPT;
         wr_ptr_reg     <= '0;
         commit_ptr_reg <= '0;
         rd_ptr_reg     <= '0;
         drop_cnt_reg   <= '0;
         frame_cnt_reg  <= '0;
         overflow_reg   <= 1'b0;
         s1_valid_reg   <= 1'b0;
         m_valid_reg    <= 1'b0;
         m_data_reg     <= '0;
         m_keep_reg     <= '0;
         m_last_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wr_ptr_reg     <= wr_ptr_next;
         commit_ptr_reg <= commit_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         drop_cnt_reg   <= drop_cnt_next;
         frame_cnt_reg  <= frame_cnt_next;
         overflow_reg   <= overflow_next;
         s1_valid_reg   <= s1_valid_next;
         m_valid_reg    <= m_valid_next;
         m_data_reg     <= m_data_next;
         m_keep_reg     <= m_keep_next;
         m_last_reg     <= m_last_next;
      end
   end

   eth_pkt_fifo_ram #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ENTRY_WIDTH (ENTRY_WIDTH)
   ) u_ram (
      .clk156  (clk156),
      .wr_en   (ram_wr_en),
      .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
      .rd_data (rd_entry)
   );

   assign m_axis_tvalid = m_valid_reg;
   assign m_axis_tdata  = m_data_reg;
   assign m_axis_tkeep  = m_keep_reg;
   assign m_axis_tlast  = m_last_reg;
   assign m_axis_tuser  = 1'b0;
   assign frame_cnt     = frame_cnt_reg;
   assign drop_cnt      = drop_cnt_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Directed bench for eth_pkt_fifo (16-beat buffer): expected output beats are queued as
// good frames are driven and compared as the DUT hands them out.
`timescale 1ns/1ps
module tb_eth_pkt_fifo;

   logic        clk156 = 1'b0;
   logic        eth_rst;
   logic        s_axis_tvalid;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tlast;
   logic        s_axis_tuser;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [31:0] frame_cnt;
   logic [31:0] drop_cnt;
   logic        overflow;

   int          checks = 0;
   int          errors = 0;
   int          ovf_seen = 0;
   int          exp_frames = 0;
   int          exp_drops = 0;
   int          ovf_before;
   logic [72:0] exp_q[$];
   logic        stall_prev = 1'b0;
   logic [72:0] held_beat;

   always #3.2 clk156 = ~clk156;

   eth_pkt_fifo #(
      .DATA_WIDTH (64),
      .KEEP_WIDTH (8),
      .ADDR_WIDTH (4),
      .CNT_WIDTH  (32)
   ) dut (
      .clk156        (clk156),
      .eth_rst       (eth_rst),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_cnt     (frame_cnt),
      .drop_cnt      (drop_cnt),
      .overflow      (overflow)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: sampled on the falling edge, between driving and active edges.
   always @(negedge clk156) begin
      logic [72:0] cur;
      logic [72:0] exp;
      cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (eth_rst) begin
         stall_prev = 1'b0;
      end else begin
         if (overflow) ovf_seen++;
         if (stall_prev) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_beat", cur, held_beat);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               check("beat", cur, exp);
            end
            $display("beat data=%h keep=%h last=%b", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         held_beat  = cur;
      end
   end

   task automatic send_frame(input int len, input logic [63:0] base, input logic [7:0] last_keep,
                             input logic bad, input logic keep_it, input logic toggle);
      logic last;
      for (int i = 1; i <= len; i++) begin
         last          = (i == len);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = base + 64'(i);
         s_axis_tkeep  = last ? last_keep : 8'hFF;
         s_axis_tlast  = last;
         s_axis_tuser  = last & bad;
         if (keep_it) exp_q.push_back({last, s_axis_tkeep, s_axis_tdata});
         if (toggle) m_axis_tready = ~m_axis_tready;
         @(posedge clk156); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic drain(input string tag, input logic toggle);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         if (toggle) m_axis_tready = ~m_axis_tready;
         @(posedge clk156); #1;
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      m_axis_tready = 1'b1;
      repeat (2) @(posedge clk156);
      #1;
      check({tag, "_idle"}, m_axis_tvalid, 0);
      check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
      check({tag, "_drop_cnt"}, drop_cnt, exp_drops);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      eth_rst       = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge clk156);
      #1;
      eth_rst = 1'b0;

      // Reset state
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tkeep", m_axis_tkeep, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tuser", m_axis_tuser, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_overflow", overflow, 0);

      // 1: 8-beat good frame, latency of two edges after the input tlast
      m_axis_tready = 1'b1;
      send_frame(8, 64'h0, 8'h0F, 1'b0, 1'b1, 1'b0);
      check("t1_lat_edge_n", m_axis_tvalid, 0);
      @(posedge clk156); #1;
      check("t1_lat_edge_n1", m_axis_tvalid, 0);
      @(posedge clk156); #1;
      check("t1_lat_edge_n2", m_axis_tvalid, 1);
      exp_frames = 1;
      drain("t1", 1'b0);

      // 2: bad frame (tuser on tlast) then a good 3-beat frame
      send_frame(5, 64'h200, 8'hFF, 1'b1, 1'b0, 1'b0);
      send_frame(3, 64'h300, 8'h03, 1'b0, 1'b1, 1'b0);
      exp_drops  = 1;
      exp_frames = 2;
      drain("t2", 1'b0);

      // 3: 20-beat frame overflows the 16-entry buffer, following 4-beat frame survives
      ovf_before = ovf_seen;
      send_frame(20, 64'h400, 8'hFF, 1'b0, 1'b0, 1'b0);
      send_frame(4, 64'h500, 8'h1F, 1'b0, 1'b1, 1'b0);
      exp_drops  = 2;
      exp_frames = 3;
      drain("t3", 1'b0);
      check("t3_overflow_pulses", ovf_seen - ovf_before, 1);

      // 4: buffer fills with four frames under back-pressure, the fifth is dropped
      m_axis_tready = 1'b0;
      ovf_before    = ovf_seen;
      for (int f = 0; f < 4; f++) begin
         send_frame(4, 64'h600 + 64'(f * 16), 8'h7F, 1'b0, 1'b1, 1'b0);
      end
      send_frame(4, 64'h700, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk156);
      #1;
      check("t4_drop_cnt_held", drop_cnt, 3);
      check("t4_overflow_pulses", ovf_seen - ovf_before, 1);
      check("t4_frame_cnt_held", frame_cnt, 3);
      m_axis_tready = 1'b1;
      exp_drops  = 3;
      exp_frames = 7;
      drain("t4", 1'b0);

      // 5: two back-to-back 6-beat frames with tready toggling every cycle
      m_axis_tready = 1'b0;
      send_frame(6, 64'h800, 8'h01, 1'b0, 1'b1, 1'b1);
      send_frame(6, 64'h900, 8'h3F, 1'b0, 1'b1, 1'b1);
      exp_frames = 9;
      drain("t5", 1'b1);

      // 6: reset while a beat is presented mid-frame
      m_axis_tready = 1'b0;
      send_frame(4, 64'hA00, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk156);
      #1;
      check("t6_pre_tvalid", m_axis_tvalid, 1);
      eth_rst = 1'b1;
      @(posedge clk156); #1;
      eth_rst = 1'b0;
      check("t6_rst_tvalid", m_axis_tvalid, 0);
      check("t6_rst_frame_cnt", frame_cnt, 0);
      check("t6_rst_drop_cnt", drop_cnt, 0);
      m_axis_tready = 1'b1;
      exp_frames    = 1;
      exp_drops     = 0;
      send_frame(2, 64'hB00, 8'h0F, 1'b0, 1'b1, 1'b0);
      drain("t6", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
